// File: rtl/rv32i_types.sv
// Shared RV32I datapath types: fetch-stage FSM state and timeout counter width.
package rv32i_types;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_DONE
  } fetch_state_t;

  localparam int unsigned FETCH_TIMEOUT_W = 8;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch stage (master) and memory (slave).
interface fetch_unit_if;

  logic        mem_read;
  logic [31:0] mem_address;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read, mem_address, mem_byte_enable,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_address, mem_byte_enable,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register: async reset to RESET_PC, load has priority over +4 increment.
module fetch_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q, pc_d;

  // Next PC: explicit load (redirect) beats sequential increment; +4 wraps mod 2^32.
  always_comb begin
    pc_d = pc_q;
    if (load_i)     pc_d = load_pc_i;
    else if (inc_i) pc_d = pc_q + 32'd4;
  end

  // PC state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem read handshake, strobes the IR.
// Optional build macro FETCH_MISALIGN_CHECK_EN: reject fetches from a non-word-aligned PC.
module fetch_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0060,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  fetch_unit_if.master       mem,
  output logic               ir_load,
  output logic [31:0]        ir_data,
  output logic [31:0]        pc_out,
  output logic               busy,
  output logic               fetch_err
);

  // Counter value on the last REQ cycle before timeout; the bus sees TIMEOUT_CYCLES cycles of mem_read.
  localparam logic [FETCH_TIMEOUT_W-1:0] TO_LAST = FETCH_TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  fetch_state_t               state_q, state_d;
  logic [FETCH_TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                       pend_q, pend_d;
  logic [31:0]                pend_pc_q, pend_pc_d;
  logic                       ir_load_q, ir_load_d;
  logic [31:0]                ir_data_q, ir_data_d;
  logic [31:0]                pc_out_q, pc_out_d;
  logic                       fetch_err_q, fetch_err_d;

  logic        pc_load, pc_inc;
  logic [31:0] pc_load_val, pc;
  logic        redir_any;
  logic [31:0] redir_tgt;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (pc_load),
    .load_pc_i (pc_load_val),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  // A redirect arriving on the same cycle as the response counts as pending; newest target wins.
  assign redir_any = pend_q | redirect_valid;
  assign redir_tgt = redirect_valid ? redirect_pc : pend_pc_q;

  // FSM next-state, counter, pending redirect and IR/PC control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;
    ir_load_d   = 1'b0;
    ir_data_d   = ir_data_q;
    pc_out_d    = pc_out_q;
    fetch_err_d = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = redirect_pc;
    pc_inc      = 1'b0;
    unique case (state_q)
      FETCH_IDLE: begin
        pend_d = 1'b0;
        cnt_d  = '0;
        if (redirect_valid) begin
          pc_load = 1'b1;
        end else if (fetch_req) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (pc[1:0] != 2'b00) fetch_err_d = 1'b1;
          else                  state_d     = FETCH_REQ;
`else
          state_d = FETCH_REQ;
`endif
        end
      end
      FETCH_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (redirect_valid) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
        if (mem.mem_resp) begin
          pend_d = 1'b0;
          if (redir_any) begin
            pc_load     = 1'b1;
            pc_load_val = redir_tgt;
            state_d     = FETCH_IDLE;
          end else begin
            ir_load_d = 1'b1;
            ir_data_d = mem.mem_rdata;
            pc_out_d  = pc;
            pc_inc    = 1'b1;
            state_d   = FETCH_DONE;
          end
        end else if (cnt_q == TO_LAST) begin
          // Timeout leaves pc alone unless control asked for a redirect meanwhile.
          fetch_err_d = 1'b1;
          pend_d      = 1'b0;
          pc_load     = redir_any;
          pc_load_val = redir_tgt;
          state_d     = FETCH_IDLE;
        end
      end
      FETCH_DONE: begin
        state_d = FETCH_IDLE;
        pc_load = redirect_valid;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  // State and output registers; reset aborts any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH_IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_pc_q   <= '0;
      ir_load_q   <= 1'b0;
      ir_data_q   <= '0;
      pc_out_q    <= RESET_PC;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      ir_load_q   <= ir_load_d;
      ir_data_q   <= ir_data_d;
      pc_out_q    <= pc_out_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign mem.mem_read        = (state_q == FETCH_REQ);
  assign mem.mem_address     = pc;
  assign mem.mem_byte_enable = 4'b1111;
  assign ir_load             = ir_load_q;
  assign ir_data             = ir_data_q;
  assign pc_out              = pc_out_q;
  assign busy                = (state_q != FETCH_IDLE);
  assign fetch_err           = fetch_err_q;

endmodule
